pll_cfg_seq: RTL and testbench

- Reconfiguration sequencer for the fractional video/system PLL; switches its output between NTSC (53.693175 MHz) and PAL (53.203425 MHz) without a new bitstream.
- Sits between the core's video-standard select and the Altera PLL reconfig controller's Avalon-MM management port.
- Issues the register writes that load M, K and C0, triggers reconfiguration, and waits for a stable lock before reporting done.

---
 rtl/pll_cfg_seq_if.sv | 24 ++
 rtl/pll_cfg_seq.sv | 169 ++++++++++++++++
 tb/tb_pll_cfg_seq.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM management port between the reconfig sequencer and the
// Altera PLL reconfig controller. Write-only: the sequencer never reads.
interface pll_cfg_seq_if;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    // Sequencer side: drives the write transfer, observes the stall.
    modport master (
        output mgmt_address,
        output mgmt_write,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    // Reconfig controller side.
    modport slave (
        input  mgmt_address,
        input  mgmt_write,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );
endinterface

// File: rtl/pll_cfg_seq.sv
// PLL reconfiguration sequencer: switches the video/system PLL between the
// NTSC and PAL output frequencies by writing M, K and C0 through the reconfig
// controller, starting the reconfiguration and waiting for a stable lock.
module pll_cfg_seq #(
    parameter logic [31:0] M_VAL        = 32'h0000_0404,
    parameter logic [31:0] C0_VAL       = 32'h0000_0404,
    parameter logic [31:0] K_NTSC       = 32'd2537930535,
    parameter logic [31:0] K_PAL        = 32'd2201376898,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_cfg_sel,
    input  logic           i_pll_locked,
    pll_cfg_seq_if.master  mgmt,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_error,
    output logic           o_cur_sel
);

    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TIMER_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(LOCK_STABLE);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(LOCK_TIMEOUT);

    // Reconfig controller register map.
    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;
    localparam logic [5:0] ADDR_K     = 6'h07;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_M,
        S_WR_K,
        S_WR_C0,
        S_WR_START,
        S_WAIT_LOCK,
        S_FIN,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_force;     // run a sequence even if the mode is unchanged
    logic                  r_tgt;       // mode being applied by the sequence in flight
    logic                  r_cur_sel;
    logic                  r_error;
    logic [STABLE_W-1:0]   r_stable;
    logic [TIMER_W-1:0]    r_timer;

    logic                  w_start;
    logic                  w_accept;
    logic                  w_write;
    logic [5:0]            w_addr;
    logic [31:0]           w_data;

    // A new sequence starts from IDLE on request change or forced retry.
    assign w_start  = (r_state == S_IDLE) && (r_force || (i_cfg_sel != r_cur_sel));
    assign w_accept = !mgmt.mgmt_waitrequest;

    // Next-state and write-port decode; each write state holds until accepted.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_next  = r_state;
        w_write = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_WR_MODE;
            end
            S_WR_MODE: begin
                w_write = 1'b1;
                w_addr  = ADDR_MODE;
                w_data  = 32'd0;        // waitrequest mode
                if (w_accept) w_next = S_WR_M;
            end
            S_WR_M: begin
                w_write = 1'b1;
                w_addr  = ADDR_M;
                w_data  = M_VAL;
                if (w_accept) w_next = S_WR_K;
            end
            S_WR_K: begin
                w_write = 1'b1;
                w_addr  = ADDR_K;
                w_data  = r_tgt ? K_PAL : K_NTSC;
                if (w_accept) w_next = S_WR_C0;
            end
            S_WR_C0: begin
                w_write = 1'b1;
                w_addr  = ADDR_C;
                w_data  = C0_VAL;
                if (w_accept) w_next = S_WR_START;
            end
            S_WR_START: begin
                // The controller stalls this write for the whole reconfiguration.
                w_write = 1'b1;
                w_addr  = ADDR_START;
                w_data  = 32'd1;
                if (w_accept) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A stable lock wins over a timeout reached in the same cycle.
                if (r_stable >= STABLE_MAX)     w_next = S_FIN;
                else if (r_timer >= TIMER_MAX)  w_next = S_ERR;
            end
            S_FIN:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset returns to IDLE, which drops mgmt_write at once.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Sequence bookkeeping: target latch, lock counters, result flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_force   <= 1'b1;
            r_tgt     <= 1'b0;
            r_cur_sel <= 1'b0;
            r_error   <= 1'b0;
            r_stable  <= '0;
            r_timer   <= '0;
        end else begin
            if (w_start) begin
                r_tgt   <= i_cfg_sel;
                r_error <= 1'b0;
                r_force <= 1'b0;
            end
            if ((r_state == S_WR_START) && w_accept) begin
                r_stable <= '0;
                r_timer  <= '0;
            end
            if (r_state == S_WAIT_LOCK) begin
                if (!i_pll_locked)             r_stable <= '0;
                else if (r_stable < STABLE_MAX) r_stable <= r_stable + 1'b1;
                if (r_timer < TIMER_MAX)       r_timer  <= r_timer + 1'b1;
            end
            if (r_state == S_FIN) r_cur_sel <= r_tgt;
            if (r_state == S_ERR) begin
                r_error <= 1'b1;
                r_force <= 1'b1;    // retry on the next IDLE cycle
            end
        end
    end

    assign mgmt.mgmt_write     = w_write;
    assign mgmt.mgmt_address   = w_addr;
    assign mgmt.mgmt_writedata = w_data;

    assign o_busy    = (r_state != S_IDLE) && (r_state != S_FIN) && (r_state != S_ERR);
    assign o_done    = (r_state == S_FIN);
    assign o_error   = r_error;
    assign o_cur_sel = r_cur_sel;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Self-checking bench for pll_cfg_seq: a transaction-level model predicts the
// expected write list and result timing, compared every cycle, plus literal
// expectations for the hand-derived latencies of each directed scenario.
module tb_pll_cfg_seq;

    localparam logic [31:0] K_NTSC = 32'd2537930535;
    localparam logic [31:0] K_PAL  = 32'd2201376898;
    localparam logic [31:0] M_VAL  = 32'h0000_0404;
    localparam logic [31:0] C0_VAL = 32'h0000_0404;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 65535;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_sel = 1'b0;
    logic locked = 1'b1;
    logic busy, done, error, cur_sel;

    pll_cfg_seq_if bus ();

    pll_cfg_seq dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cfg_sel    (cfg_sel),
        .i_pll_locked (locked),
        .mgmt         (bus),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_cur_sel    (cur_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name, input int cyc);
        n_checks++;
        $display("FAIL %s: event not seen within %0d cycles", name, cyc);
    endtask

    // ---------------- model ----------------
    // Phases: 0 idle, 1 writing, 2 waiting for lock, 3 done cycle, 4 error cycle.
    wr_t  m_q[$];
    int   m_phase = 0;
    logic m_valid = 1'b0;
    logic m_force = 1'b1;
    logic m_err = 1'b0;
    logic m_cur = 1'b0;
    logic m_tgt = 1'b0;
    int   m_run = 0;
    int   m_elapsed = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_force = 1'b1;
            m_err   = 1'b0;
            m_cur   = 1'b0;
            m_valid = 1'b1;
        end else begin
            case (m_phase)
                0: if (m_force || cfg_sel != m_cur) begin
                    m_tgt   = cfg_sel;
                    m_err   = 1'b0;
                    m_force = 1'b0;
                    m_q.push_back('{a: 6'h00, d: 32'd0});
                    m_q.push_back('{a: 6'h04, d: M_VAL});
                    m_q.push_back('{a: 6'h07, d: cfg_sel ? K_PAL : K_NTSC});
                    m_q.push_back('{a: 6'h05, d: C0_VAL});
                    m_q.push_back('{a: 6'h02, d: 32'd1});
                    m_phase = 1;
                end
                1: if (!bus.mgmt_waitrequest) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_phase   = 2;
                        m_run     = 0;
                        m_elapsed = 0;
                    end
                end
                2: begin
                    if (m_run >= LOCK_STABLE)            m_phase = 3;
                    else if (m_elapsed >= LOCK_TIMEOUT)  m_phase = 4;
                    else begin
                        m_run = locked ? m_run + 1 : 0;
                        m_elapsed++;
                    end
                end
                3: begin
                    m_cur   = m_tgt;
                    m_phase = 0;
                end
                default: begin
                    m_err   = 1'b1;
                    m_force = 1'b1;
                    m_phase = 0;
                end
            endcase
        end
    end

    // Per-cycle compare, half a cycle after the edge.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("busy",    busy,    (m_phase == 1 || m_phase == 2));
            check("done",    done,    (m_phase == 3));
            check("error",   error,   m_err);
            check("cur_sel", cur_sel, m_cur);
            check("write",   bus.mgmt_write, (m_phase == 1));
            check("address", bus.mgmt_address,   (m_phase == 1) ? m_q[0].a : 6'h00);
            check("wdata",   bus.mgmt_writedata, (m_phase == 1) ? m_q[0].d : 32'd0);
        end
    end

    // Accepted-write log, taken from the DUT port for literal checks.
    wr_t log_q[$];
    initial forever begin
        @(negedge clk);
        if (!rst && bus.mgmt_write && !bus.mgmt_waitrequest)
            log_q.push_back('{a: bus.mgmt_address, d: bus.mgmt_writedata});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts edges until done (which=0) or error (which=1) is seen; ends on a negedge.
    task automatic wait_sig(input int which, input int max_cyc, input string tag, output int edges);
        edges = 0;
        while (1) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if ((which == 0 && done) || (which == 1 && error)) return;
            if (edges >= max_cyc) begin
                timeout_fail(tag, max_cyc);
                return;
            end
        end
    endtask

    // Ends on the negedge where a write to address a is being driven.
    task automatic wait_addr(input logic [5:0] a, input int max_cyc, input string tag);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (bus.mgmt_write && bus.mgmt_address == a) return;
            n++;
            if (n >= max_cyc) begin
                timeout_fail(tag, max_cyc);
                return;
            end
        end
    endtask

    task automatic check_writes(input string tag, input logic [31:0] k);
        check({tag, "_nwr"}, log_q.size(), 5);
        if (log_q.size() == 5) begin
            check({tag, "_a0"}, log_q[0].a, 6'h00); check({tag, "_d0"}, log_q[0].d, 32'd0);
            check({tag, "_a1"}, log_q[1].a, 6'h04); check({tag, "_d1"}, log_q[1].d, 32'h404);
            check({tag, "_a2"}, log_q[2].a, 6'h07); check({tag, "_d2"}, log_q[2].d, k);
            check({tag, "_a3"}, log_q[3].a, 6'h05); check({tag, "_d3"}, log_q[3].d, 32'h404);
            check({tag, "_a4"}, log_q[4].a, 6'h02); check({tag, "_d4"}, log_q[4].d, 32'd1);
        end
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "simulation stalled");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int e;
        int n_start;
        bus.mgmt_waitrequest = 1'b0;

        // 1: reset release, NTSC forced sequence; done 6 + 16 + 1 edges later.
        step(3);
        check("rst_write", bus.mgmt_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        log_q.delete();
        rst = 1'b0;
        wait_sig(0, 100, "t1_done_timeout", e);
        check("t1_done_edge", e, 23);
        check_writes("t1", 32'd2537930535);
        step(1);
        check("t1_cur", cur_sel, 1'b0);
        check("t1_done_pulse", done, 1'b0);

        // 2: switch to PAL.
        log_q.delete();
        cfg_sel = 1'b1;
        wait_sig(0, 100, "t2_done_timeout", e);
        check("t2_done_edge", e, 23);
        check_writes("t2", 32'd2201376898);
        step(1);
        check("t2_cur", cur_sel, 1'b1);

        // 3: controller stalls the start write for 40 cycles.
        log_q.delete();
        cfg_sel = 1'b0;
        wait_addr(6'h05, 50, "t3_c0_timeout");
        @(posedge clk); #1;
        bus.mgmt_waitrequest = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("t3_hold_addr", bus.mgmt_address, 6'h02);
        check("t3_hold_data", bus.mgmt_writedata, 32'd1);
        check("t3_hold_write", bus.mgmt_write, 1'b1);
        repeat (20) @(posedge clk); #1;
        bus.mgmt_waitrequest = 1'b0;
        wait_sig(0, 100, "t3_done_timeout", e);
        check("t3_release_to_done", e, 18);
        n_start = 0;
        foreach (log_q[i]) if (log_q[i].a == 6'h02) n_start++;
        check("t3_start_accepts", n_start, 1);
        step(1);
        check("t3_cur", cur_sel, 1'b0);

        // 4: lock drops once at stable count 10; count restarts.
        cfg_sel = 1'b1;
        wait_addr(6'h02, 50, "t4_start_timeout");
        @(posedge clk); #1;                 // start accepted on this edge
        repeat (10) @(posedge clk); #1;
        locked = 1'b0;
        @(posedge clk); #1;
        locked = 1'b1;
        wait_sig(0, 100, "t4_done_timeout", e);
        check("t4_relock_to_done", e, 17);
        step(1);
        check("t4_cur", cur_sel, 1'b1);

        // 5: lock never arrives -> timeout error, then automatic retry.
        cfg_sel = 1'b0;
        locked = 1'b0;
        wait_addr(6'h02, 50, "t5_start_timeout");
        @(posedge clk); #1;
        wait_sig(1, 70000, "t5_error_timeout", e);
        check("t5_error_edge", e, LOCK_TIMEOUT + 2);
        check("t5_cur_kept", cur_sel, 1'b1);
        check("t5_error_busy", busy, 1'b0);
        @(posedge clk); #1;
        locked = 1'b1;
        check("t5_error_cleared", error, 1'b0);
        check("t5_retry_busy", busy, 1'b1);
        wait_sig(0, 100, "t5_done_timeout", e);
        check("t5_retry_done_edge", e, 22);
        step(1);
        check("t5_cur", cur_sel, 1'b0);

        // 6: cfg_sel glitch while busy triggers no extra sequence.
        cfg_sel = 1'b1;
        wait_addr(6'h07, 50, "t6_k_timeout");
        @(posedge clk); #1;
        cfg_sel = 1'b0;
        @(posedge clk); #1;
        cfg_sel = 1'b1;
        wait_sig(0, 100, "t6_done_timeout", e);
        step(4);
        check("t6_no_restart", busy, 1'b0);
        check("t6_cur", cur_sel, 1'b1);

        // 7: reset mid-write, then forced sequence for the current cfg_sel.
        cfg_sel = 1'b0;
        wait_addr(6'h04, 50, "t7_m_timeout");
        @(posedge clk); #1;
        check("t7_in_wr_k", bus.mgmt_address, 6'h07);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t7_write_dropped", bus.mgmt_write, 1'b0);
        check("t7_cur_reset", cur_sel, 1'b0);
        log_q.delete();
        rst = 1'b0;
        wait_sig(0, 100, "t7_done_timeout", e);
        check("t7_done_edge", e, 23);
        check_writes("t7", 32'd2537930535);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
